cpc_printer_port: RTL
=====================

Name: cpc_printer_port

Overview:
- Responder on the CPC Z80 I/O bus for the Centronics printer port at &EFxx.
- Decodes CPU writes and tracks the STROBE bit in data bit 7. Each completed strobe pulse becomes one printed byte, which is pushed into a FIFO.
- Drains the FIFO to a host-side consumer through a valid/ready stream.
- Drives the BUSY line that feeds PPI port B bit 6.

Parameters:
- FIFO_DEPTH, 16, number of byte entries; must be a power of 2 and at least 2.
- BUSY_TICKS, 16, minimum BUSY duration after a capture, counted in ce_4p ticks; range 1..255.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous reset, active-low.
- ce_4p  input  1  4 MHz clock enable; BUSY timing advances only on these ticks.
- cpu_addr  input  16  Z80 address bus.
- cpu_dout  input  8  Z80 write data.
- io_wr  input  1  I/O write strobe, active-high; may stay high for several clk cycles.
- busy  output  1  printer BUSY, active-high, goes to PPI port B bit 6.
- out_data  output  8  byte at the FIFO head, formatted {1'b0, data[6:0]}.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Select: sel = io_wr & ~cpu_addr[12]. A write event is the 0→1 edge of sel, registered on clk. One event per bus cycle, however long io_wr is held.
- Latch: on each write event, port_latch[7:0] <= cpu_dout. The strobe level is port_latch[7]; 1 means STROBE is asserted.
- Capture: a 0→1 transition of port_latch[7] captures data = cpu_dout[6:0] from that same write. Writes that keep bit 7 at 1 do not capture again. Writes with bit 7 = 0 only update the latch.
- State machine:
  - IDLE: busy=0. A capture pushes the byte into the FIFO (or sets overflow if the FIFO is full). Go to HOLD and load cnt=BUSY_TICKS.
  - HOLD: busy=1. cnt decrements on each ce_4p tick. When cnt=0 and port_latch[7]=0, go to IDLE. When cnt=0 and port_latch[7]=1, go to WAIT_REL.
  - WAIT_REL: busy=1. When port_latch[7]=0, go to IDLE.
  - A capture can occur in any state. A capture while busy=1 is still accepted (CPC software polls BUSY, but the hardware does not block): push the byte and reload cnt; from WAIT_REL this cannot occur because port_latch[7] is already 1.
- busy is also forced to 1 whenever the FIFO is full, in every state: busy = (state!=IDLE) | full.
- FIFO: synchronous, with registered pointers that wrap modulo FIFO_DEPTH.
  - Push in the capture cycle. Pop when out_valid & out_ready.
  - Push and pop in the same cycle when full: both happen and the level is unchanged, so no overflow.
  - Push when full with no pop: byte dropped, overflow <= 1.
  - out_data is valid in the same cycle as out_valid (show-ahead, first-word fall-through). The first byte appears at the output 1 clk after its capture cycle.
- Latency: write edge to capture is 1 clk. busy rises the clk after capture.
- overflow clears only on reset.
- Reset (asynchronous, active-low, honoured at any point including mid-strobe or mid-HOLD), all values: state=IDLE, port_latch=8'h00, cnt=0, FIFO empty, out_valid=0, out_data=8'h00, fifo_level=0, overflow=0, busy=0.

Test Plan:
- Single strobe: write &EF00 with 8'h41, then 8'hC1 (bit 7 set), then 8'h41 → one push, out_data=8'h41. busy=1 for 16 ce_4p ticks, then 0.
- Held strobe: write 8'hC1, then 8'hC2, with no release → only 8'h41 is captured. busy stays 1 in WAIT_REL until 8'h42 (bit 7 clear) is written, then drops.
- Address decode: a write with bit 7 set to &FF00 (A12=1) → no latch change, no push. io_wr held high for 20 clk on one &EF00 write → exactly one event.
- Fill: FIFO_DEPTH+1 strobes with out_ready=0 → fifo_level=16, busy stays 1 while full, 17th byte dropped and overflow=1. Next, one pop with a simultaneous strobe → level stays 16 and overflow is unchanged.
- Drain order: bytes 8'h01..8'h05 strobed in, then out_ready=1 → output order 01..05, out_valid drops after the 5th byte, level returns to 0.
- Reset mid-HOLD with 3 bytes queued: assert reset_n=0 asynchronously → busy=0, level=0 and out_valid=0 immediately. The next strobe after release captures normally.

Source files
------------

// File: rtl/cpc_printer_port.sv
// ---------------------------------------------------------------------------
// cpc_printer_port
//   Centronics printer port responder for the CPC Z80 I/O bus (&EFxx).
//   CPU writes are decoded on A12=0. Bit 7 of the written byte is STROBE.
//   Every rising STROBE captures the low seven data bits into a show-ahead
//   FIFO, which drains to a host consumer over a valid/ready stream.
//   BUSY (to PPI port B bit 6) is held for at least BUSY_TICKS ce_4p ticks
//   after each capture. It is held until STROBE is released, and it is also
//   held whenever the FIFO is full.
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   ce_4p          4 MHz enable; only the BUSY hold counter uses it
//   cpu_addr       Z80 address bus (only A12 is decoded)
//   cpu_dout       Z80 write data
//   io_wr          I/O write strobe, may be held for many clk cycles
//   busy           printer BUSY, active-high
//   out_data       FIFO head {1'b0, data[6:0]}, 8'h00 while empty
//   out_valid      FIFO not empty
//   out_ready      consumer accepts out_data
//   fifo_level     current FIFO occupancy
//   overflow       sticky: a captured byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module cpc_printer_port #(
  parameter int FIFO_DEPTH = 16,
  parameter int BUSY_TICKS = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ce_4p,
  input  logic [15:0]                   cpu_addr,
  input  logic [7:0]                    cpu_dout,
  input  logic                          io_wr,
  output logic                          busy,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] LVL_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [7:0]  TICKS_INIT = 8'(BUSY_TICKS);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    HOLD     = 2'b01,
    WAIT_REL = 2'b10
  } state_t;

  // Bus decode and capture stage
  logic          sel_s;
  logic          wr_ev_s;
  logic          sel_r;
  logic [7:0]    port_latch_r;
  logic          cap_r;
  logic [6:0]    cap_data_r;

  // FIFO
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [AW:0]   level_next_s;
  logic          full_s;
  logic          full_next_s;
  logic          push_s;
  logic          pop_s;
  logic          valid_r;
  logic          overflow_r;

  // BUSY state machine
  state_t        state_r;
  state_t        state_next_s;
  logic [7:0]    cnt_r;
  logic [7:0]    cnt_next_s;
  logic          busy_r;

  // Only A12 takes part in the decode; the remaining address bits are unused.
  logic          unused_addr_s;
  assign unused_addr_s = ^{cpu_addr[15:13], cpu_addr[11:0]};

  assign sel_s   = io_wr & ~cpu_addr[12];
  // A long io_wr pulse gives a single event, on its first clk.
  assign wr_ev_s = sel_s & ~sel_r;

  // Write-event detection, port latch and one-clk capture pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_r        <= 1'b0;
      port_latch_r <= 8'h00;
      cap_r        <= 1'b0;
      cap_data_r   <= 7'h00;
    end else begin
      sel_r <= sel_s;
      if (wr_ev_s) begin
        port_latch_r <= cpu_dout;
        // Capture only on a 0->1 STROBE transition; held STROBE does not repeat.
        cap_r        <= cpu_dout[7] & ~port_latch_r[7];
        if (cpu_dout[7] & ~port_latch_r[7]) begin
          cap_data_r <= cpu_dout[6:0];
        end else begin
          cap_data_r <= cap_data_r;
        end
      end else begin
        cap_r <= 1'b0;
      end
    end
  end

  assign full_s = (level_r == FULL_LVL);
  assign pop_s  = valid_r & out_ready;
  // If a pop frees a slot in the same cycle, a push onto a full FIFO still fits.
  assign push_s = cap_r & (~full_s | pop_s);

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
    full_next_s = (level_next_s == FULL_LVL);
  end

  // FIFO storage; contents need no reset because out_data is gated by valid
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {1'b0, cap_data_r};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, level, valid and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      level_r    <= level_next_s;
      valid_r    <= (level_next_s != '0);
      overflow_r <= overflow_r | (cap_r & full_s & ~pop_s);
    end
  end

  // BUSY next state: a capture always (re)starts the hold period
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (cap_r) begin
      state_next_s = HOLD;
      cnt_next_s   = TICKS_INIT;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
        end
        HOLD: begin
          if (cnt_r == 8'd0) begin
            if (port_latch_r[7]) begin
              state_next_s = WAIT_REL;
            end else begin
              state_next_s = IDLE;
            end
          end else if (ce_4p) begin
            cnt_next_s = cnt_r - 8'd1;
          end else begin
            cnt_next_s = cnt_r;
          end
        end
        WAIT_REL: begin
          if (!port_latch_r[7]) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = WAIT_REL;
          end
        end
        default: begin
          state_next_s = IDLE;
          cnt_next_s   = 8'd0;
        end
      endcase
    end
  end

  // BUSY state register; busy is registered from the next state and fill level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= (state_next_s != IDLE) | full_next_s;
    end
  end

  assign busy       = busy_r;
  assign out_valid  = valid_r;
  assign out_data   = valid_r ? mem_r[rd_ptr_r] : 8'h00;
  assign fifo_level = level_r;
  assign overflow   = overflow_r;

endmodule
